// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, ALU select bits,
// state encoding, instruction classes and the bundle of datapath strobes.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_DIV = 3;
  localparam int ALU_SHR = 4;
  localparam int ALU_SHL = 5;
  localparam int ALU_ROR = 6;
  localparam int ALU_ROL = 7;
  localparam int ALU_AND = 8;
  localparam int ALU_OR  = 9;
  localparam int ALU_NEG = 10;
  localparam int ALU_NOT = 11;

  localparam logic [3:0] S_FETCH0 = 4'd0;
  localparam logic [3:0] S_FWAIT  = 4'd1;
  localparam logic [3:0] S_FETCH2 = 4'd2;
  localparam logic [3:0] S_FETCH3 = 4'd3;
  localparam logic [3:0] S_T4     = 4'd4;
  localparam logic [3:0] S_T5     = 4'd5;
  localparam logic [3:0] S_T6     = 4'd6;
  localparam logic [3:0] S_T7     = 4'd7;
  localparam logic [3:0] S_T8     = 4'd8;
  localparam logic [3:0] S_T9     = 4'd9;
  localparam logic [3:0] S_HALTED = 4'd10;

  typedef enum logic [3:0] {
    IC_ALU, IC_ALUI, IC_MULDIV, IC_UNARY, IC_LD, IC_LDI, IC_ST, IC_BR,
    IC_JR, IC_JAL, IC_IN, IC_OUT, IC_MFHI, IC_MFLO, IC_NOP, IC_HALT
  } instr_class_t;

  typedef struct packed {
    logic inc_pc, read, write;
    logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out, inport_out;
    logic pc_in, mdr_in, mar_in, ir_in, y_in, zhi_in, zlo_in, hi_in, lo_in;
    logic outport_in, conff_in;
    logic g_ra, g_rb, g_rc, r_in, r_out, ba_out;
    logic [11:0] alu_op;
  } ctrl_t;

  function automatic logic [11:0] alu_bit(input int idx);
    return 12'd1 << idx;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Maps an opcode to its execute-sequence class and the one-hot ALU operation it selects.
module instr_class_decode
  import mini_src_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t iclass,
  output logic [11:0]  alu_op
);

  always_comb begin
    iclass = IC_NOP;
    alu_op = '0;
    case (opcode)
      OP_LD:   iclass = IC_LD;
      OP_LDI:  iclass = IC_LDI;
      OP_ST:   iclass = IC_ST;
      OP_ADD:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_ADD); end
      OP_SUB:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_SUB); end
      OP_AND:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_AND); end
      OP_OR:   begin iclass = IC_ALU;    alu_op = alu_bit(ALU_OR);  end
      OP_ROR:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_ROR); end
      OP_ROL:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_ROL); end
      OP_SHR:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_SHR); end
      OP_SHL:  begin iclass = IC_ALU;    alu_op = alu_bit(ALU_SHL); end
      OP_ADDI: begin iclass = IC_ALUI;   alu_op = alu_bit(ALU_ADD); end
      OP_ANDI: begin iclass = IC_ALUI;   alu_op = alu_bit(ALU_AND); end
      OP_ORI:  begin iclass = IC_ALUI;   alu_op = alu_bit(ALU_OR);  end
      OP_MUL:  begin iclass = IC_MULDIV; alu_op = alu_bit(ALU_MUL); end
      OP_DIV:  begin iclass = IC_MULDIV; alu_op = alu_bit(ALU_DIV); end
      OP_NEG:  begin iclass = IC_UNARY;  alu_op = alu_bit(ALU_NEG); end
      OP_NOT:  begin iclass = IC_UNARY;  alu_op = alu_bit(ALU_NOT); end
      OP_BR:   iclass = IC_BR;
      OP_JR:   iclass = IC_JR;
      OP_JAL:  iclass = IC_JAL;
      OP_IN:   iclass = IC_IN;
      OP_OUT:  iclass = IC_OUT;
      OP_MFHI: iclass = IC_MFHI;
      OP_MFLO: iclass = IC_MFLO;
      OP_HALT: iclass = IC_HALT;
      // shra and the unassigned 111xx codes fall through as nop
      default: iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle sequencer for the Mini SRC datapath: fetch, decode of IR[31:27],
// and one T-state of control strobes per clock, with stall and halt handling.
module control_unit
  import mini_src_pkg::*;
#(
  parameter int FETCH_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        ConFF,
  input  logic        Stop,
  output logic        Run,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZHI_Out,
  output logic        ZLO_Out,
  output logic        HI_Out,
  output logic        LO_Out,
  output logic        C_Out,
  output logic        InPort_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZHI_In,
  output logic        ZLO_In,
  output logic        HI_In,
  output logic        LO_In,
  output logic        OutPort_In,
  output logic        ConFF_In,
  output logic        G_RA,
  output logic        G_RB,
  output logic        G_RC,
  output logic        R_In,
  output logic        R_Out,
  output logic        BA_Out,
  output logic [11:0] ALU_Op
);

  localparam logic [1:0] WAIT_INIT = 2'(FETCH_WAIT - 1);

  logic [3:0]   state_reg, state_next, last_state;
  logic [1:0]   wait_reg, wait_next;
  instr_class_t iclass;
  logic [11:0]  class_alu;
  ctrl_t        ctrl, ctrl_gated;
  logic         run_raw;
  logic         unused_ir;

  assign unused_ir = ^IR[26:0];

  instr_class_decode u_decode (
    .opcode (IR[31:27]),
    .iclass (iclass),
    .alu_op (class_alu)
  );

  always_comb begin
    case (iclass)
      IC_ALU, IC_ALUI, IC_LDI: last_state = S_T6;
      IC_MULDIV, IC_BR:        last_state = S_T7;
      IC_UNARY, IC_JAL:        last_state = S_T5;
      IC_LD:                   last_state = S_T9;
      IC_ST:                   last_state = S_T8;
      default:                 last_state = S_T4;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      S_FETCH0: if (!Stop) begin
        state_next = S_FWAIT;
        wait_next  = WAIT_INIT;
      end
      S_FWAIT: begin
        if (wait_reg == 2'd0) state_next = S_FETCH2;
        else                  wait_next  = wait_reg - 2'd1;
      end
      S_FETCH2: state_next = S_FETCH3;
      S_FETCH3: state_next = S_T4;
      S_HALTED: state_next = S_HALTED;
      S_T4, S_T5, S_T6, S_T7, S_T8, S_T9: begin
        if (state_reg == last_state) begin
          state_next = (iclass == IC_HALT) ? S_HALTED : S_FETCH0;
        end else if (state_reg == S_T7 && iclass == IC_LD) begin
          // T7 of a load repeats to cover the memory read latency
          if (wait_reg == 2'd0) state_next = S_T8;
          else                  wait_next  = wait_reg - 2'd1;
        end else begin
          state_next = state_reg + 4'd1;
          if (state_reg == S_T6) wait_next = WAIT_INIT;
        end
      end
      default: state_next = S_FETCH0;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_reg <= S_FETCH0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    ctrl    = '0;
    run_raw = 1'b1;
    case (state_reg)
      S_FETCH0: begin
        if (Stop) run_raw = 1'b0;
        else begin
          ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
        end
      end
      S_FWAIT:  ctrl.read = 1'b1;
      S_FETCH2: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
      S_FETCH3: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_T4, S_T5, S_T6, S_T7, S_T8, S_T9: begin
        case (iclass)
          IC_ALU, IC_ALUI: case (state_reg)
            S_T4: begin ctrl.g_rb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            S_T5: begin
              if (iclass == IC_ALUI) ctrl.c_out = 1'b1;
              else begin ctrl.g_rc = 1'b1; ctrl.r_out = 1'b1; end
              ctrl.alu_op = class_alu; ctrl.zlo_in = 1'b1;
            end
            S_T6: begin ctrl.zlo_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
          IC_MULDIV: case (state_reg)
            S_T4: begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            S_T5: begin
              ctrl.g_rb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = class_alu;
              ctrl.zhi_in = 1'b1; ctrl.zlo_in = 1'b1;
            end
            S_T6: begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; end
            S_T7: begin ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1; end
            default: ;
          endcase
          IC_UNARY: case (state_reg)
            S_T4: begin
              ctrl.g_rb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = class_alu; ctrl.zlo_in = 1'b1;
            end
            S_T5: begin ctrl.zlo_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
          IC_LD, IC_LDI, IC_ST: case (state_reg)
            S_T4: begin ctrl.g_rb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
            S_T5: begin ctrl.c_out = 1'b1; ctrl.alu_op = alu_bit(ALU_ADD); ctrl.zlo_in = 1'b1; end
            S_T6: begin
              ctrl.zlo_out = 1'b1;
              if (iclass == IC_LDI) begin ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
              else ctrl.mar_in = 1'b1;
            end
            S_T7: begin
              if (iclass == IC_ST) begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
              else ctrl.read = 1'b1;
            end
            S_T8: begin
              if (iclass == IC_ST) ctrl.write = 1'b1;
              else begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
            end
            S_T9: begin ctrl.mdr_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
          IC_BR: case (state_reg)
            S_T4: begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.conff_in = 1'b1; end
            S_T5: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
            S_T6: begin ctrl.c_out = 1'b1; ctrl.alu_op = alu_bit(ALU_ADD); ctrl.zlo_in = 1'b1; end
            S_T7: if (ConFF) begin ctrl.zlo_out = 1'b1; ctrl.pc_in = 1'b1; end
            default: ;
          endcase
          IC_JR: begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          IC_JAL: case (state_reg)
            S_T4: begin ctrl.pc_out = 1'b1; ctrl.g_rb = 1'b1; ctrl.r_in = 1'b1; end
            S_T5: begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
            default: ;
          endcase
          IC_IN:   begin ctrl.inport_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
          IC_OUT:  begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
          IC_MFHI: begin ctrl.hi_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
          IC_MFLO: begin ctrl.lo_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: run_raw = 1'b0;
    endcase
  end

  // Reset held low silences every output, even though the state already sits in FETCH0
  assign ctrl_gated = Clear ? ctrl : '0;
  assign Run        = Clear & run_raw;
  assign IncPC      = ctrl_gated.inc_pc;
  assign Read       = ctrl_gated.read;
  assign Write      = ctrl_gated.write;
  assign PC_Out     = ctrl_gated.pc_out;
  assign MDR_Out    = ctrl_gated.mdr_out;
  assign ZHI_Out    = ctrl_gated.zhi_out;
  assign ZLO_Out    = ctrl_gated.zlo_out;
  assign HI_Out     = ctrl_gated.hi_out;
  assign LO_Out     = ctrl_gated.lo_out;
  assign C_Out      = ctrl_gated.c_out;
  assign InPort_Out = ctrl_gated.inport_out;
  assign PC_In      = ctrl_gated.pc_in;
  assign MDR_In     = ctrl_gated.mdr_in;
  assign MAR_In     = ctrl_gated.mar_in;
  assign IR_In      = ctrl_gated.ir_in;
  assign Y_In       = ctrl_gated.y_in;
  assign ZHI_In     = ctrl_gated.zhi_in;
  assign ZLO_In     = ctrl_gated.zlo_in;
  assign HI_In      = ctrl_gated.hi_in;
  assign LO_In      = ctrl_gated.lo_in;
  assign OutPort_In = ctrl_gated.outport_in;
  assign ConFF_In   = ctrl_gated.conff_in;
  assign G_RA       = ctrl_gated.g_ra;
  assign G_RB       = ctrl_gated.g_rb;
  assign G_RC       = ctrl_gated.g_rc;
  assign R_In       = ctrl_gated.r_in;
  assign R_Out      = ctrl_gated.r_out;
  assign BA_Out     = ctrl_gated.ba_out;
  assign ALU_Op     = ctrl_gated.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected strobe vectors are queued per instruction
// and compared every cycle on the falling clock edge.
module tb_control_unit;

  localparam int FW = 1;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] IR    = 32'h0;
  logic        ConFF = 1'b0;
  logic        Stop  = 1'b0;
  logic Run, IncPC, Read, Write, PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out;
  logic InPort_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In;
  logic OutPort_In, ConFF_In, G_RA, G_RB, G_RC, R_In, R_Out, BA_Out;
  logic [11:0] ALU_Op;

  always #5 Clock = ~Clock;

  control_unit #(.FETCH_WAIT(FW)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .ConFF(ConFF), .Stop(Stop),
    .Run(Run), .IncPC(IncPC), .Read(Read), .Write(Write),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZHI_Out(ZHI_Out), .ZLO_Out(ZLO_Out),
    .HI_Out(HI_Out), .LO_Out(LO_Out), .C_Out(C_Out), .InPort_Out(InPort_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZHI_In(ZHI_In), .ZLO_In(ZLO_In), .HI_In(HI_In), .LO_In(LO_In),
    .OutPort_In(OutPort_In), .ConFF_In(ConFF_In), .G_RA(G_RA), .G_RB(G_RB),
    .G_RC(G_RC), .R_In(R_In), .R_Out(R_Out), .BA_Out(BA_Out), .ALU_Op(ALU_Op)
  );

  localparam logic [40:0] RUN   = 41'd1 << 40;
  localparam logic [40:0] INC   = 41'd1 << 39;
  localparam logic [40:0] RD    = 41'd1 << 38;
  localparam logic [40:0] WR    = 41'd1 << 37;
  localparam logic [40:0] PCO   = 41'd1 << 36;
  localparam logic [40:0] MDRO  = 41'd1 << 35;
  localparam logic [40:0] ZHIO  = 41'd1 << 34;
  localparam logic [40:0] ZLOO  = 41'd1 << 33;
  localparam logic [40:0] HIO   = 41'd1 << 32;
  localparam logic [40:0] LOO   = 41'd1 << 31;
  localparam logic [40:0] CO    = 41'd1 << 30;
  localparam logic [40:0] INPO  = 41'd1 << 29;
  localparam logic [40:0] PCI   = 41'd1 << 28;
  localparam logic [40:0] MDRI  = 41'd1 << 27;
  localparam logic [40:0] MARI  = 41'd1 << 26;
  localparam logic [40:0] IRI   = 41'd1 << 25;
  localparam logic [40:0] YI    = 41'd1 << 24;
  localparam logic [40:0] ZHII  = 41'd1 << 23;
  localparam logic [40:0] ZLOI  = 41'd1 << 22;
  localparam logic [40:0] HII   = 41'd1 << 21;
  localparam logic [40:0] LOI   = 41'd1 << 20;
  localparam logic [40:0] OUTPI = 41'd1 << 19;
  localparam logic [40:0] CONI  = 41'd1 << 18;
  localparam logic [40:0] GRA   = 41'd1 << 17;
  localparam logic [40:0] GRB   = 41'd1 << 16;
  localparam logic [40:0] GRC   = 41'd1 << 15;
  localparam logic [40:0] RI    = 41'd1 << 14;
  localparam logic [40:0] RO    = 41'd1 << 13;
  localparam logic [40:0] BAO   = 41'd1 << 12;
  localparam logic [40:0] A_ADD = 41'd1;
  localparam logic [40:0] DRIVERS = PCO | MDRO | ZHIO | ZLOO | HIO | LOO | CO | INPO | RO | BAO;

  logic [40:0] obs;
  assign obs = {Run, IncPC, Read, Write, PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out,
                C_Out, InPort_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In,
                HI_In, LO_In, OutPort_In, ConFF_In, G_RA, G_RB, G_RC, R_In, R_Out, BA_Out,
                ALU_Op};

  logic [40:0] exp_q[$];
  string       tag_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [40:0] got, input logic [40:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [40:0] v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  function automatic logic [40:0] alu(input logic [4:0] op);
    int b;
    logic [40:0] a;
    a = '0;
    case (op)
      5'b00011, 5'b01100: b = 0;
      5'b00100:           b = 1;
      5'b01111:           b = 2;
      5'b10000:           b = 3;
      5'b01001:           b = 4;
      5'b01011:           b = 5;
      5'b00111:           b = 6;
      5'b01000:           b = 7;
      5'b00101, 5'b01101: b = 8;
      5'b00110, 5'b01110: b = 9;
      5'b10001:           b = 10;
      5'b10010:           b = 11;
      default:            b = -1;
    endcase
    if (b >= 0) a = 41'd1 << b;
    return a;
  endfunction

  task automatic push_fetch();
    push(RUN | PCO | MARI | INC, "F0");
    for (int i = 0; i < FW; i++) push(RUN | RD, "FWAIT");
    push(RUN | RD | MDRI, "F2");
    push(RUN | MDRO | IRI, "F3");
  endtask

  task automatic push_exec(input logic [4:0] op, input logic cf);
    string n;
    n = $sformatf("op%b", op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01011: begin
        push(RUN | GRB | RO | YI, {n, " T4"});
        push(RUN | GRC | RO | alu(op) | ZLOI, {n, " T5"});
        push(RUN | ZLOO | GRA | RI, {n, " T6"});
      end
      5'b01100, 5'b01101, 5'b01110: begin
        push(RUN | GRB | RO | YI, {n, " T4"});
        push(RUN | CO | alu(op) | ZLOI, {n, " T5"});
        push(RUN | ZLOO | GRA | RI, {n, " T6"});
      end
      5'b01111, 5'b10000: begin
        push(RUN | GRA | RO | YI, {n, " T4"});
        push(RUN | GRB | RO | alu(op) | ZHII | ZLOI, {n, " T5"});
        push(RUN | ZLOO | LOI, {n, " T6"});
        push(RUN | ZHIO | HII, {n, " T7"});
      end
      5'b10001, 5'b10010: begin
        push(RUN | GRB | RO | alu(op) | ZLOI, {n, " T4"});
        push(RUN | ZLOO | GRA | RI, {n, " T5"});
      end
      5'b00000, 5'b00001, 5'b00010: begin
        push(RUN | GRB | BAO | YI, {n, " T4"});
        push(RUN | CO | A_ADD | ZLOI, {n, " T5"});
        if (op == 5'b00001) push(RUN | ZLOO | GRA | RI, {n, " T6"});
        else push(RUN | ZLOO | MARI, {n, " T6"});
        if (op == 5'b00000) begin
          for (int i = 0; i < FW; i++) push(RUN | RD, {n, " rdwait"});
          push(RUN | RD | MDRI, {n, " rd"});
          push(RUN | MDRO | GRA | RI, {n, " wb"});
        end else if (op == 5'b00010) begin
          push(RUN | GRA | RO | MDRI, {n, " T7"});
          push(RUN | WR, {n, " T8"});
        end
      end
      5'b10011: begin
        push(RUN | GRA | RO | CONI, {n, " T4"});
        push(RUN | PCO | YI, {n, " T5"});
        push(RUN | CO | A_ADD | ZLOI, {n, " T6"});
        push(cf ? (RUN | ZLOO | PCI) : RUN, {n, cf ? " T7 taken" : " T7 not taken"});
      end
      5'b10100: push(RUN | GRA | RO | PCI, {n, " T4"});
      5'b10101: begin
        push(RUN | PCO | GRB | RI, {n, " T4"});
        push(RUN | GRA | RO | PCI, {n, " T5"});
      end
      5'b10110: push(RUN | INPO | GRA | RI, {n, " T4"});
      5'b10111: push(RUN | GRA | RO | OUTPI, {n, " T4"});
      5'b11000: push(RUN | HIO | GRA | RI, {n, " T4"});
      5'b11001: push(RUN | LOO | GRA | RI, {n, " T4"});
      default:  push(RUN, {n, " T4"});
    endcase
  endtask

  task automatic drain();
    logic [40:0] e;
    string t;
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_value(t, obs, e);
      check_value({t, " one-driver"}, {40'd0, $countones(obs & DRIVERS) > 1}, 41'd0);
      check_value({t, " rd-wr"}, {40'd0, Read & Write}, 41'd0);
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic cf);
    @(posedge Clock);
    #1;
    Clear = 1'b1;
    Stop  = 1'b0;
    IR    = ir;
    ConFF = cf;
    push_fetch();
    push_exec(ir[31:27], cf);
    drain();
    $display("instr ir=%h conff=%0d done checks=%0d failures=%0d", ir, cf, checks, failures);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) push('0, "reset");
    drain();
    run_instr(32'h0000_0000, 1'b0);
    run_instr(32'h1891_8000, 1'b0);
    run_instr(32'h0090_0065, 1'b0);
    for (int i = 0; i < 32; i++) begin
      logic [4:0] op;
      op = 5'(i);
      if (op != 5'b11011) run_instr({op, 27'h0123456}, 1'b0);
    end
    run_instr(32'h9800_0000, 1'b1);
    run_instr(32'h7800_0000, 1'b0);

    // stall in FETCH0, then Stop raised mid-instruction must be ignored
    @(posedge Clock);
    #1;
    Stop = 1'b1;
    IR   = 32'hD000_0000;
    repeat (3) push('0, "stall");
    drain();
    @(posedge Clock);
    #1;
    Stop = 1'b0;
    IR   = 32'h1891_8000;
    push_fetch();
    drain();
    #1 Stop = 1'b1;
    push_exec(5'b00011, 1'b0);
    push('0, "stall after instr");
    drain();
    $display("stall sequence done checks=%0d failures=%0d", checks, failures);

    // Clear pulled low in the middle of T5
    run_instr(32'hD000_0000, 1'b0);
    @(posedge Clock);
    #1;
    IR = 32'h1891_8000;
    push_fetch();
    push(RUN | GRB | RO | YI, "preclr T4");
    push(RUN | GRC | RO | A_ADD | ZLOI, "preclr T5");
    drain();
    #1 Clear = 1'b0;
    push('0, "clr held");
    push('0, "clr held");
    drain();
    run_instr(32'h1891_8000, 1'b0);

    // halt: one empty T4, then silent forever
    @(posedge Clock);
    #1;
    IR = 32'hD800_0000;
    push_fetch();
    push(RUN, "halt T4");
    repeat (22) push('0, "halted");
    drain();
    $display("halt sequence done checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
